// File: rtl/latch_ctrl_pkg.sv
// Shared definitions for the latch write arbiter: FSM states and default sizing.
package latch_ctrl_pkg;

  localparam int NREQ_DEF     = 4;
  localparam int DW_DEF       = 8;
  localparam int HOLD_CYC_DEF = 2;
  localparam int HOLD_W       = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CAPT = 2'd1,
    HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/latch_wr_arbiter_rr_pick.sv
// Combinational round-robin search starting one past the previous winner.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   last_id_i,
  output logic [IW-1:0]   win_o,
  output logic            valid_o
);

  int unsigned idx;
  logic        found;

  always_comb begin
    win_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = (32'(last_id_i) + k) % NREQ;
      if (!found && req_i[IW'(idx)]) begin
        found = 1'b1;
        win_o = IW'(idx);
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/latch_wr_arbiter.sv
// Round-robin arbiter granting one requester at a time a write into a shared external level latch.
module latch_wr_arbiter
  import latch_ctrl_pkg::*;
#(
  parameter int NREQ     = NREQ_DEF,
  parameter int DW       = DW_DEF,
  parameter int HOLD_CYC = HOLD_CYC_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*DW-1:0]       req_data,
  output logic [NREQ-1:0]          gnt,
  output logic                     lat_en,
  output logic [DW-1:0]            lat_d,
  output logic                     busy,
  output logic [$clog2(NREQ)-1:0]  last_id
);

  localparam int IW = $clog2(NREQ);

  state_e              state_q, state_d;
  logic [IW-1:0]       last_id_q, last_id_d;
  logic [DW-1:0]       lat_d_q, lat_d_d;
  logic [HOLD_W-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]       win;
  logic                win_valid;
  logic [DW-1:0]       win_data;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req_i     (req),
    .last_id_i (last_id_q),
    .win_o     (win),
    .valid_o   (win_valid)
  );

  always_comb begin
    win_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (win == IW'(i)) win_data = req_data[i*DW +: DW];
    end
  end

  always_comb begin
    state_d   = state_q;
    last_id_d = last_id_q;
    lat_d_d   = lat_d_q;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: begin
        if (win_valid) begin
          state_d   = CAPT;
          last_id_d = win;
          lat_d_d   = win_data;
        end
      end
      CAPT: begin
        if (HOLD_CYC > 0) begin
          state_d = HOLD;
          cnt_d   = HOLD_W'(HOLD_CYC);
        end else begin
          state_d = IDLE;
        end
      end
      HOLD: begin
        // counter reaches zero on the HOLD->IDLE edge, matching its reset value
        cnt_d = cnt_q - HOLD_W'(1);
        if (cnt_q <= HOLD_W'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      last_id_q <= IW'(NREQ - 1);
      lat_d_q   <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      last_id_q <= last_id_d;
      lat_d_q   <= lat_d_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    gnt = '0;
    if (state_q == CAPT) gnt[last_id_q] = 1'b1;
  end

  assign lat_en  = (state_q == CAPT);
  assign busy    = (state_q != IDLE);
  assign lat_d   = lat_d_q;
  assign last_id = last_id_q;

endmodule

// File: tb/tb_latch_wr_arbiter.sv
// Scoreboard bench: two arbiters (lockout 2 and 0) driven by requester models, checked against a transaction-level reference.
module tb_latch_wr_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int IW   = 2;
  localparam int NI   = 2;

  typedef struct {
    int id;
    int data;
    int c;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NI-1:0][NREQ-1:0]    req;
  logic [NI-1:0][NREQ*DW-1:0] rdata;
  logic [NI-1:0][NREQ-1:0]    gnt;
  logic [NI-1:0]              lat_en;
  logic [NI-1:0][DW-1:0]      lat_d;
  logic [NI-1:0]              busy;
  logic [NI-1:0][IW-1:0]      last_id;

  logic sticky = 1'b0;
  logic rnd    = 1'b0;
  logic done   = 1'b0;

  int cyc = 0;
  int nxt      [NI];
  int busy_end [NI];
  int last     [NI];
  int mlat     [NI];
  exp_t q0[$];
  exp_t q1[$];

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  latch_wr_arbiter #(.NREQ(NREQ), .DW(DW), .HOLD_CYC(2)) u_dut_h2 (
    .clk(clk), .rst(rst), .req(req[0]), .req_data(rdata[0]), .gnt(gnt[0]),
    .lat_en(lat_en[0]), .lat_d(lat_d[0]), .busy(busy[0]), .last_id(last_id[0])
  );

  latch_wr_arbiter #(.NREQ(NREQ), .DW(DW), .HOLD_CYC(0)) u_dut_h0 (
    .clk(clk), .rst(rst), .req(req[1]), .req_data(rdata[1]), .gnt(gnt[1]),
    .lat_en(lat_en[1]), .lat_d(lat_d[1]), .busy(busy[1]), .last_id(last_id[1])
  );

  function automatic int hold_of(input int k);
    return (k == 0) ? 2 : 0;
  endfunction

  // Reference: an arbiter accepts one request per lockout window and picks the
  // first requester at or after last+1 in circular order.
  initial begin
    for (int k = 0; k < NI; k++) begin
      nxt[k] = 0; busy_end[k] = -1; last[k] = NREQ - 1; mlat[k] = 0;
    end
    forever begin
      @(posedge clk);
      cyc++;
      for (int k = 0; k < NI; k++) begin
        if (rst) begin
          nxt[k] = cyc + 1; busy_end[k] = cyc - 1; last[k] = NREQ - 1; mlat[k] = 0;
        end else if (cyc >= nxt[k] && req[k] != '0) begin
          int w;
          exp_t e;
          w = -1;
          for (int off = 1; off <= NREQ; off++) begin
            int cand;
            cand = (last[k] + off) % NREQ;
            if (w < 0 && req[k][cand]) w = cand;
          end
          last[k]     = w;
          mlat[k]     = int'(rdata[k][w*DW +: DW]);
          nxt[k]      = cyc + hold_of(k) + 2;
          busy_end[k] = cyc + hold_of(k);
          e.id = w; e.data = mlat[k]; e.c = cyc;
          if (k == 0) q0.push_back(e); else q1.push_back(e);
        end
      end
    end
  end

  task automatic chk(input string nm, input int k, input int act, input int expv);
    n_vec++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s inst%0d cyc%0d: got %0h expected %0h", nm, k, cyc, act, expv);
    end
  endtask

  function automatic int qsize(input int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  function automatic exp_t qpop(input int k);
    if (k == 0) return q0.pop_front();
    return q1.pop_front();
  endfunction

  function automatic int qhead_c(input int k);
    return (k == 0) ? q0[0].c : q1[0].c;
  endfunction

  // Monitor
  initial begin
    forever begin
      @(negedge clk);
      if (cyc > 0) begin
        for (int k = 0; k < NI; k++) begin
          exp_t e;
          chk("busy", k, int'(busy[k]), (cyc <= busy_end[k]) ? 1 : 0);
          chk("lat_d", k, int'(lat_d[k]), mlat[k]);
          chk("last_id", k, int'(last_id[k]), last[k]);
          if (gnt[k] != '0 || lat_en[k]) begin
            if (qsize(k) == 0) begin
              chk("spurious_gnt", k, int'({lat_en[k], gnt[k]}), 0);
            end else begin
              e = qpop(k);
              chk("gnt", k, int'(gnt[k]), 1 << e.id);
              chk("lat_en", k, int'(lat_en[k]), 1);
              chk("gnt_data", k, int'(lat_d[k]), e.data);
              chk("gnt_cycle", k, cyc, e.c);
            end
          end else if (qsize(k) > 0 && qhead_c(k) <= cyc) begin
            e = qpop(k);
            chk("missing_gnt", k, 0, 1 << e.id);
          end
        end
      end
      if (done) begin
        for (int k = 0; k < NI; k++) chk("drained", k, qsize(k), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
      end
    end
  end

  // Requesters: hold req/data until granted, drop it during the grant cycle.
  task automatic step();
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (gnt[k][i] && !sticky) req[k][i] = 1'b0;
        if (rnd && !req[k][i] && $urandom_range(0, 3) == 0) begin
          req[k][i] = 1'b1;
          rdata[k][i*DW +: DW] = DW'($urandom);
        end
      end
    end
    if (rnd) rst = ($urandom_range(0, 63) == 0);
  endtask

  task automatic set_req(input logic [NREQ-1:0] r);
    for (int k = 0; k < NI; k++) req[k] = r;
  endtask

  task automatic set_data(input int i, input logic [DW-1:0] v);
    for (int k = 0; k < NI; k++) rdata[k][i*DW +: DW] = v;
  endtask

  task automatic do_reset();
    set_req('0);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    req = '0;
    for (int k = 0; k < NI; k++)
      for (int i = 0; i < NREQ; i++) rdata[k][i*DW +: DW] = DW'($urandom);

    // requests present during reset are ignored, then granted 0..3 in order
    set_req(4'b1111);
    repeat (3) step();
    rst = 1'b0;
    repeat (20) step();

    // single requester, data A5
    do_reset();
    set_data(0, 8'hA5);
    set_req(4'b0001);
    repeat (8) step();

    // all requesters held continuously
    do_reset();
    sticky = 1'b1;
    for (int i = 0; i < NREQ; i++) set_data(i, DW'(8'h10 + i));
    set_req(4'b1111);
    repeat (22) step();
    sticky = 1'b0;
    repeat (20) step();

    // wrap from last_id=3
    do_reset();
    set_data(0, 8'h3C); set_data(3, 8'hC3);
    set_req(4'b1001);
    repeat (12) step();

    // request arriving during lockout
    do_reset();
    set_data(0, 8'h21); set_data(1, 8'h77);
    set_req(4'b0001);
    step();
    step();
    for (int k = 0; k < NI; k++) req[k][1] = 1'b1;
    repeat (10) step();

    // reset during the grant cycle
    do_reset();
    step();
    set_data(0, 8'h5A);
    set_req(4'b0001);
    step();
    rst = 1'b1;
    set_data(1, 8'h61); set_data(2, 8'h62);
    set_req(4'b0110);
    step();
    rst = 1'b0;
    repeat (12) step();

    // single continuous requester: lockout period visible per instance
    do_reset();
    sticky = 1'b1;
    set_data(0, 8'h99);
    set_req(4'b0001);
    repeat (12) step();
    sticky = 1'b0;
    repeat (8) step();

    // random traffic with occasional resets
    do_reset();
    rnd = 1'b1;
    repeat (500) step();
    rnd = 1'b0;
    rst = 1'b0;
    repeat (30) step();
    done = 1'b1;
  end

endmodule
